io_event_arbiter: RTL and testbench

Shares the single write port of the 8-bit user-IO event FIFO (CPU-visible, read via `io_fifo_rd_en`) between several independent event sources: button parser, rotary parser, and future sources. Each source gets a one-deep pending slot, so a one-cycle event pulse is never lost while the FIFO write port is busy. Pending slots are served round-robin and respect FIFO backpressure. Events that cannot be held are counted in a saturating drop counter for software diagnostics. The block replaces the ad-hoc button-to-FIFO write logic in the top level.

---
 rtl/io_event_arbiter.sv | 126 ++++++++++++
 tb/tb_io_event_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/io_event_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_SRC event sources, each with a one-deep pending slot.
// Optional: define IO_EVENT_ARB_COALESCE_EN to OR colliding events into the slot instead of dropping them.
module io_event_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_mask,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [NUM_SRC-1:0]            pending,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count,
  input  logic                          drop_clear
);

  localparam int SUM_W = DROP_CNT_WIDTH + 4;

  logic [DATA_WIDTH-1:0]     r_slot [NUM_SRC];
  logic [NUM_SRC-1:0]        r_pending;
  logic [2:0]                r_rr_ptr;
  logic                      r_wr_en;
  logic [DATA_WIDTH-1:0]     r_din;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  logic [NUM_SRC-1:0] w_capture;
  logic [NUM_SRC-1:0] w_granted;
  logic [NUM_SRC-1:0] w_collide;
  logic [NUM_SRC-1:0] w_drop;
  logic               w_grant;
  logic               w_found;
  logic [2:0]         w_win;
  logic [2:0]         w_rr_next;
  logic [3:0]         w_drop_num;

  // Clamp at the counter maximum; the 4 extra bits hold up to 8 simultaneous drops.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_add(
    input logic [DROP_CNT_WIDTH-1:0] cnt,
    input logic [3:0]                num
  );
    logic [SUM_W-1:0] sum;
    sum = {4'b0000, cnt} + SUM_W'(num);
    if (sum > {4'b0000, {DROP_CNT_WIDTH{1'b1}}}) return {DROP_CNT_WIDTH{1'b1}};
    return sum[DROP_CNT_WIDTH-1:0];
  endfunction

  // Requiring an idle write cycle makes fifo_full always reflect the previous write.
  assign w_grant   = (|r_pending) & ~fifo_full & ~r_wr_en;
  assign w_capture = src_valid & src_mask;
  assign w_collide = w_capture & r_pending & ~w_granted;
  assign w_rr_next = (w_win == 3'(NUM_SRC - 1)) ? 3'd0 : w_win + 3'd1;

`ifdef IO_EVENT_ARB_COALESCE_EN
  assign w_drop = '0;
`else
  assign w_drop = w_collide;
`endif

  // First pending source scanning from r_rr_ptr upward, modulo NUM_SRC.
  always_comb begin
    w_win   = 3'd0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!w_found && r_pending[i] &&
            ((int'(r_rr_ptr) + k == i) || (int'(r_rr_ptr) + k == i + NUM_SRC))) begin
          w_win   = 3'(i);
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_granted[i] = w_grant && (w_win == 3'(i));
    end
  end

  always_comb begin
    w_drop_num = 4'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_drop_num = w_drop_num + 4'(w_drop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_rr_ptr   <= 3'd0;
      r_wr_en    <= 1'b0;
      r_din      <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_slot[i] <= '0;
    end else begin
      r_wr_en <= w_grant;
      if (w_grant) r_rr_ptr <= w_rr_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_granted[i]) r_din <= r_slot[i];
        // A capture on the grant edge refills the slot while the old word goes out.
        if (w_capture[i] && !w_collide[i]) begin
          r_slot[i]    <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
          r_pending[i] <= 1'b1;
`ifdef IO_EVENT_ARB_COALESCE_EN
        end else if (w_collide[i]) begin
          r_slot[i] <= r_slot[i] | src_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
        end else if (w_granted[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
      if (drop_clear) r_drop_cnt <= '0;
      else if (|w_drop) r_drop_cnt <= sat_add(r_drop_cnt, w_drop_num);
    end
  end

  assign fifo_wr_en = r_wr_en;
  assign fifo_din   = r_din;
  assign pending    = r_pending;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_io_event_arbiter.sv
// Directed bench for io_event_arbiter (NUM_SRC=4, DROP_CNT_WIDTH=2); expectations follow IO_EVENT_ARB_COALESCE_EN.
module tb_io_event_arbiter;

`ifdef IO_EVENT_ARB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_mask;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [3:0]  pending;
  logic [1:0]  drop_count;
  logic        drop_clear;

  int n_checks = 0;
  int n_errors = 0;

  io_event_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .DROP_CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .src_mask(src_mask), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .pending(pending), .drop_count(drop_count),
    .drop_clear(drop_clear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got %0b exp 0", fifo_wr_en); end
    n_checks++; if (fifo_din !== 8'h00) begin n_errors++; $display("FAIL reset_din got %h exp 00", fifo_din); end
    n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL reset_pending got %b exp 0000", pending); end
    n_checks++; if (drop_count !== 2'd0) begin n_errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
  endtask

  task automatic test_single();
    src_valid = 4'b0100; src_data = 32'h0040_0000;
    tick();
    src_valid = 4'b0000;
    n_checks++; if (pending !== 4'b0100 || fifo_wr_en !== 1'b0) begin n_errors++; $display("FAIL single_capture got pending=%b wr=%0b exp 0100/0", pending, fifo_wr_en); end
    tick();
    n_checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h40) begin n_errors++; $display("FAIL single_write got wr=%0b din=%h exp 1/40", fifo_wr_en, fifo_din); end
    n_checks++; if (pending !== 4'b0000) begin n_errors++; $display("FAIL single_pending_clr got %b exp 0000", pending); end
    tick();
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_errors++; $display("FAIL single_one_cycle got wr=%0b exp 0", fifo_wr_en); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      src_valid = 4'b1111; src_data = 32'h4433_2211;
      tick();
      src_valid = 4'b0000;
      n_checks++; if (pending !== 4'b1111) begin n_errors++; $display("FAIL rr_capture%0d got %b exp 1111", r, pending); end
      for (int k = 0; k < 4; k++) begin
        tick();
        n_checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== exp_d[k]) begin n_errors++; $display("FAIL rr%0d_write%0d got wr=%0b din=%h exp 1/%h", r, k, fifo_wr_en, fifo_din, exp_d[k]); end
        tick();
        n_checks++; if (fifo_wr_en !== 1'b0) begin n_errors++; $display("FAIL rr%0d_gap%0d got wr=%0b exp 0", r, k, fifo_wr_en); end
      end
    end
  endtask

  task automatic test_backpressure();
    fifo_full = 1'b1;
    src_valid = 4'b0010; src_data = 32'h0000_0800;
    tick();
    src_valid = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      n_checks++; if (fifo_wr_en !== 1'b0 || pending !== 4'b0010) begin n_errors++; $display("FAIL bp_stall%0d got wr=%0b pending=%b exp 0/0010", c, fifo_wr_en, pending); end
      tick();
    end
    fifo_full = 1'b0;
    tick();
    n_checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h08) begin n_errors++; $display("FAIL bp_release got wr=%0b din=%h exp 1/08", fifo_wr_en, fifo_din); end
    tick();
    n_checks++; if (fifo_wr_en !== 1'b0 || pending !== 4'b0000) begin n_errors++; $display("FAIL bp_after got wr=%0b pending=%b exp 0/0000", fifo_wr_en, pending); end
  endtask

  task automatic test_collision();
    logic [1:0] exp_drop;
    logic [7:0] exp_din;
    exp_drop = COAL ? 2'd0 : 2'd1;
    exp_din  = COAL ? 8'h84 : 8'h80;
    do_reset();
    fifo_full = 1'b1;
    src_valid = 4'b0001; src_data = 32'h0000_0080;
    tick();
    src_data = 32'h0000_0004;
    tick();
    src_valid = 4'b0000;
    n_checks++; if (drop_count !== exp_drop || pending !== 4'b0001) begin n_errors++; $display("FAIL coll_state got drop=%0d pending=%b exp %0d/0001", drop_count, pending, exp_drop); end
    fifo_full = 1'b0;
    tick();
    n_checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== exp_din) begin n_errors++; $display("FAIL coll_write got wr=%0b din=%h exp 1/%h", fifo_wr_en, fifo_din, exp_din); end
    tick();
    n_checks++; if (fifo_wr_en !== 1'b0 || pending !== 4'b0000) begin n_errors++; $display("FAIL coll_after got wr=%0b pending=%b exp 0/0000", fifo_wr_en, pending); end
  endtask

  task automatic test_overlap();
    do_reset();
    src_valid = 4'b1000; src_data = 32'h0100_0000;
    tick();
    src_data = 32'h0200_0000;
    tick();
    src_valid = 4'b0000;
    n_checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h01 || pending !== 4'b1000) begin n_errors++; $display("FAIL ovl_first got wr=%0b din=%h pending=%b exp 1/01/1000", fifo_wr_en, fifo_din, pending); end
    tick();
    n_checks++; if (fifo_wr_en !== 1'b0 || pending !== 4'b1000) begin n_errors++; $display("FAIL ovl_gap got wr=%0b pending=%b exp 0/1000", fifo_wr_en, pending); end
    tick();
    n_checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h02 || pending !== 4'b0000) begin n_errors++; $display("FAIL ovl_second got wr=%0b din=%h pending=%b exp 1/02/0000", fifo_wr_en, fifo_din, pending); end
    n_checks++; if (drop_count !== 2'd0) begin n_errors++; $display("FAIL ovl_drop got %0d exp 0", drop_count); end
    tick();
  endtask

  task automatic test_counter();
    logic [1:0] e2, e3, e1;
    e2 = COAL ? 2'd0 : 2'd2;
    e3 = COAL ? 2'd0 : 2'd3;
    e1 = COAL ? 2'd0 : 2'd1;
    fifo_full = 1'b1;
    src_valid = 4'b0011; src_data = 32'h0000_B0A0;
    tick();
    n_checks++; if (pending !== 4'b0011 || drop_count !== 2'd0) begin n_errors++; $display("FAIL cnt_fill got pending=%b drop=%0d exp 0011/0", pending, drop_count); end
    tick();
    n_checks++; if (drop_count !== e2) begin n_errors++; $display("FAIL cnt_two got %0d exp %0d", drop_count, e2); end
    tick();
    n_checks++; if (drop_count !== e3) begin n_errors++; $display("FAIL cnt_sat got %0d exp %0d", drop_count, e3); end
    src_valid = 4'b0001;
    tick();
    n_checks++; if (drop_count !== e3) begin n_errors++; $display("FAIL cnt_sat_hold got %0d exp %0d", drop_count, e3); end
    drop_clear = 1'b1;
    tick();
    drop_clear = 1'b0;
    n_checks++; if (drop_count !== 2'd0) begin n_errors++; $display("FAIL cnt_clear_prio got %0d exp 0", drop_count); end
    tick();
    n_checks++; if (drop_count !== e1) begin n_errors++; $display("FAIL cnt_after_clear got %0d exp %0d", drop_count, e1); end
    src_mask = 4'b1100; src_valid = 4'b0111; src_data = 32'h0055_B0A0;
    tick();
    src_valid = 4'b0000; src_mask = 4'b1111;
    n_checks++; if (drop_count !== e1 || pending !== 4'b0111) begin n_errors++; $display("FAIL cnt_masked got drop=%0d pending=%b exp %0d/0111", drop_count, pending, e1); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (fifo_wr_en !== 1'b0 || fifo_din !== 8'h00 || pending !== 4'b0000 || drop_count !== 2'd0) begin n_errors++; $display("FAIL cnt_rst got wr=%0b din=%h pending=%b drop=%0d exp 0/00/0000/0", fifo_wr_en, fifo_din, pending, drop_count); end
    fifo_full = 1'b0;
    tick();
    tick();
    n_checks++; if (fifo_wr_en !== 1'b0 || drop_count !== 2'd0) begin n_errors++; $display("FAIL cnt_rst_discard got wr=%0b drop=%0d exp 0/0", fifo_wr_en, drop_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; src_valid = 4'b0000; src_data = 32'h0; src_mask = 4'b1111;
    fifo_full = 1'b0; drop_clear = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_collision();
    test_overlap();
    test_counter();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
